// File: rtl/instruction_set_pkg.sv
// Shared memory-op encodings and load/store FSM states for the pipeline.
package instruction_set;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RESP  = 2'b10
   } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, drives the data memory for one cycle,
// and holds a tagged response until writeback consumes it.
module load_store_unit
   import instruction_set::*;
#(
   parameter int unsigned ADDR_LIMIT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [2:0]  req_rd,
   output logic [1:0]  mem_op,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_write_data,
   input  logic [15:0] mem_read_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [2:0]  rsp_rd,
   output logic        rsp_fault,
   output logic        busy
);

   lsu_state_t state_q;
   logic       accept;
   logic       legal;

   assign req_ready = reset && ((state_q == IDLE) || (state_q == RESP && rsp_ready));
   assign busy      = (state_q != IDLE);

   // Zero-extend the address so the range check sees all 16 bits against the limit.
   always_comb begin
      accept = req_valid && req_ready;
      legal  = ((req_op == MEM_READ) || (req_op == MEM_WRITE)) &&
               ({16'b0, req_addr} < ADDR_LIMIT);
   end

   // NOTE: all state here updates with <= so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         mem_op         <= MEM_NONE;
         mem_addr       <= '0;
         mem_write_data <= '0;
         rsp_valid      <= 1'b0;
         rsp_data       <= '0;
         rsp_rd         <= '0;
         rsp_fault      <= 1'b0;
      end else begin
         mem_op <= MEM_NONE;
         case (state_q)
            ISSUE: begin
               state_q   <= RESP;
               rsp_valid <= 1'b1;
               rsp_data  <= (mem_op == MEM_READ) ? mem_read_data : 16'h0000;
            end
            IDLE, RESP: begin
               if (accept) begin
                  rsp_rd <= req_rd;
                  if (legal) begin
                     state_q        <= ISSUE;
                     mem_op         <= req_op;
                     mem_addr       <= req_addr;
                     mem_write_data <= req_wdata;
                     rsp_valid      <= 1'b0;
                     rsp_fault      <= 1'b0;
                  end else begin
                     // Faults never touch memory; the response is ready next cycle.
                     state_q   <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_fault <= 1'b1;
                     rsp_data  <= '0;
                  end
               end else if (state_q == RESP && rsp_ready) begin
                  state_q   <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural data memory.
module tb_load_store_unit;
   import instruction_set::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [2:0]  req_rd;
   logic [1:0]  mem_op;
   logic [15:0] mem_addr;
   logic [15:0] mem_write_data;
   logic [15:0] mem_read_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_rd;
   logic        rsp_fault;
   logic        busy;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  rd;
      logic        fault;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] mem [0:255];

   load_store_unit #(.ADDR_LIMIT(256)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_rd         (req_rd),
      .mem_op         (mem_op),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_rd         (rsp_rd),
      .rsp_fault      (rsp_fault),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write commits at the edge closing a MEM_WRITE cycle.
   assign mem_read_data = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (mem_op == MEM_WRITE) mem[mem_addr[7:0]] <= mem_write_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every consumed response is compared against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_rd", rsp_rd, e.rd);
               check("rsp_fault", rsp_fault, e.fault);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Present a request and return just after its acceptance edge.
   task automatic drive(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [2:0] rd);
      int n;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      req_rd    = rd;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic do_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [2:0] rd, input logic [15:0] exp_data, input logic exp_fault);
      exp_q.push_back('{data: exp_data, rd: rd, fault: exp_fault});
      drive(op, addr, wdata, rd);
      @(negedge clk);
      if (exp_fault) begin
         check("fault_mem_op_none", mem_op, MEM_NONE);
         check("fault_rsp_n1", rsp_valid, 1);
      end else begin
         check("issue_mem_op", mem_op, op);
         check("issue_mem_addr", mem_addr, addr);
         check("issue_rsp_low", rsp_valid, 0);
         @(negedge clk);
         check("resp_mem_op_none", mem_op, MEM_NONE);
         check("resp_rsp_n2", rsp_valid, 1);
      end
   endtask

   initial begin
      logic [15:0] snap_data;
      logic [2:0]  snap_rd;
      logic        snap_fault;

      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_op    = MEM_NONE;
      req_addr  = '0;
      req_wdata = '0;
      req_rd    = '0;
      rsp_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_req_ready", req_ready, 0);
      check("reset_outputs", {mem_op, mem_addr, mem_write_data, rsp_valid, rsp_data, rsp_rd, rsp_fault}, 0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Basic store/load and boundary address.
      do_req(MEM_WRITE, 16'h0010, 16'hBEEF, 3'd1, 16'h0000, 1'b0);
      do_req(MEM_READ,  16'h0010, 16'h0000, 3'd3, 16'hBEEF, 1'b0);
      do_req(MEM_WRITE, 16'h00FF, 16'h1234, 3'd2, 16'h0000, 1'b0);
      do_req(MEM_READ,  16'h00FF, 16'hFFFF, 3'd4, 16'h1234, 1'b0);

      // Faults: out of range, illegal opcodes.
      do_req(MEM_READ,  16'h0100, 16'h0000, 3'd5, 16'h0000, 1'b1);
      do_req(2'b11,     16'h0001, 16'h0000, 3'd6, 16'h0000, 1'b1);
      do_req(MEM_NONE,  16'h0002, 16'h0000, 3'd7, 16'h0000, 1'b1);
      do_req(MEM_WRITE, 16'hFF10, 16'hAAAA, 3'd0, 16'h0000, 1'b1);
      do_req(MEM_READ,  16'h0010, 16'h0000, 3'd1, 16'hBEEF, 1'b0);

      // Backpressure, then response handshake and new acceptance in the same cycle.
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      exp_q.push_back('{data: 16'hBEEF, rd: 3'd2, fault: 1'b0});
      drive(MEM_READ, 16'h0010, 16'h0000, 3'd2);
      @(negedge clk);
      check("bp_issue_mem_op", mem_op, MEM_READ);
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, 16'hBEEF);
      snap_data  = rsp_data;
      snap_rd    = rsp_rd;
      snap_fault = rsp_fault;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_stable", {rsp_valid, rsp_data, rsp_rd, rsp_fault}, {1'b1, snap_data, snap_rd, snap_fault});
         check("bp_req_ready_low", req_ready, 0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      exp_q.push_back('{data: 16'h1234, rd: 3'd5, fault: 1'b0});
      req_valid = 1'b1;
      req_op    = MEM_READ;
      req_addr  = 16'h00FF;
      req_rd    = 3'd5;
      @(negedge clk);
      check("b2b_req_ready", req_ready, 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("b2b_no_idle_mem_op", mem_op, MEM_READ);
      check("b2b_busy", busy, 1);
      @(negedge clk);
      check("b2b_rsp_valid", rsp_valid, 1);

      // Reset during ISSUE of a write: operation aborts but the write still commits.
      drive(MEM_WRITE, 16'h0030, 16'h7777, 3'd6);
      reset = 1'b0;
      @(negedge clk);
      check("abort_wr_issue", mem_op, MEM_WRITE);
      @(negedge clk);
      check("abort_wr_busy", busy, 0);
      check("abort_wr_outputs", {mem_op, mem_addr, mem_write_data, rsp_valid, rsp_data, rsp_rd, rsp_fault}, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      do_req(MEM_READ, 16'h0030, 16'h0000, 3'd7, 16'h7777, 1'b0);

      // Reset during ISSUE of a read: no response ever appears.
      drive(MEM_READ, 16'h0010, 16'h0000, 3'd1);
      reset = 1'b0;
      @(negedge clk);
      check("abort_rd_issue", mem_op, MEM_READ);
      @(negedge clk);
      check("abort_rd_busy", busy, 0);
      check("abort_rd_outputs", {mem_op, mem_addr, mem_write_data, rsp_valid, rsp_data, rsp_rd, rsp_fault}, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_rd_no_rsp", rsp_valid, 0);
      end

      repeat (3) @(posedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_LIMIT, 256, number of valid data words; addresses >= ADDR_LIMIT fault.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 req_valid  in  1  execute stage presents a memory request.
REQ-005 req_ready  out  1  unit accepts the request this cycle.
REQ-006 req_op  in  2  MEM_READ or MEM_WRITE; any other code is illegal.
REQ-007 req_addr  in  16  word address.
REQ-008 req_wdata  in  16  store data; ignored for reads.
REQ-009 req_rd  in  3  destination register tag, returned with the response.
REQ-010 mem_op  out  2  registered op to the data memory; MEM_NONE when idle.
REQ-011 mem_addr  out  16  registered address to the data memory.
REQ-012 mem_write_data  out  16  registered store data to the data memory.
REQ-013 mem_read_data  in  16  combinational read data from the data memory, valid in the same cycle as mem_op=MEM_READ.
REQ-014 rsp_valid  out  1  response available.
REQ-015 rsp_ready  in  1  writeback stage consumes the response.
REQ-016 rsp_data  out  16  load data; 0 for stores and faults.
REQ-017 rsp_rd  out  3  tag of the completed request.
REQ-018 rsp_fault  out  1  illegal op or out-of-range address.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-021 A request SHALL be accepted when req_valid && req_ready, and all request fields SHALL be registered at acceptance.
REQ-022 req_ready SHALL be 1 in IDLE, and 1 in RESP only in cycles where rsp_ready=1; it SHALL be 0 in ISSUE.
REQ-023 A legal request (op MEM_READ/MEM_WRITE and addr < ADDR_LIMIT) SHALL go to ISSUE, driving mem_op/mem_addr/mem_write_data for exactly one cycle.
REQ-024 In ISSUE with MEM_READ, mem_read_data SHALL be captured into rsp_data at the closing edge; in ISSUE with MEM_WRITE, rsp_data SHALL be 0.
REQ-025 ISSUE SHALL always go to RESP on the next edge.
REQ-026 An illegal request SHALL go directly to RESP with rsp_fault=1 and rsp_data=0, and mem_op SHALL never leave MEM_NONE for it.
REQ-027 Latency SHALL be: accepted at edge N, mem_op active in cycle N+1, rsp_valid high from cycle N+2 (faults: rsp_valid from N+1).
REQ-028 rsp_valid, rsp_data, rsp_rd and rsp_fault SHALL hold stable while rsp_valid && !rsp_ready.
REQ-029 In RESP, rsp_ready=1 with no new request SHALL return the FSM to IDLE.
REQ-030 In RESP, a simultaneous rsp handshake and request acceptance SHALL go to ISSUE, or to RESP for a faulting request, with no idle cycle.
REQ-031 mem_op SHALL be MEM_NONE in every cycle outside ISSUE.
REQ-032 An address check SHALL compare all 16 bits, with no truncation or wrap: 0x00FF is legal and 0x0100 faults at ADDR_LIMIT=256.

Reset
REQ-033 While reset=0 at an edge, the unit SHALL enter IDLE with mem_op=MEM_NONE, mem_addr=0, mem_write_data=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_fault=0 and busy=0.
REQ-034 reset asserted during ISSUE SHALL abort the operation, and no response SHALL be produced.
REQ-035 The abort SHALL not suppress the write: a MEM_WRITE already on mem_op in that cycle still commits at that edge.
REQ-036 req_ready SHALL be 0 while reset=0.

Structure
REQ-037 MEM_NONE/MEM_READ/MEM_WRITE encodings and the lsu_state_t enum (IDLE, ISSUE, RESP) SHALL live in the instruction_set package.
REQ-038 The block SHALL be a single module with no sub-modules.

Verification
REQ-039 Read: write 0xBEEF at addr 0x0010, then read 0x0010 with rd=3 -> mem_op=MEM_READ one cycle, rsp_valid at N+2, rsp_data=0xBEEF, rsp_rd=3, rsp_fault=0.
REQ-040 Store: write 0x1234 to 0x00FF -> mem_op=MEM_WRITE exactly one cycle, rsp_data=0, rsp_fault=0, and a follow-up read returns 0x1234.
REQ-041 Fault: read 0x0100, then op 2'b11 at 0x0001 -> mem_op stays MEM_NONE, rsp_fault=1, rsp_valid at N+1 for each.
REQ-042 Backpressure and back-to-back: hold rsp_ready=0 for 5 cycles -> outputs stable; then rsp_ready=1 with a new req_valid in the same cycle -> accepted with no idle cycle.
REQ-043 Reset mid-op: reset=0 in the ISSUE cycle of a read -> next cycle IDLE, all outputs at reset values, no rsp_valid.
